// File: rtl/fifo_word_packer.sv
// Packs DATA_W-wide bytes read from a first-word-fall-through-less fifo into
// LANES-byte output words, with a flush request that emits a partial word.
module fifo_word_packer #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_empty,
    input  logic [DATA_W-1:0]            fifo_data,
    output logic                         fifo_rd_en,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W*LANES-1:0]      out_data,
    output logic [$clog2(LANES+1)-1:0]   out_bytes
);
    localparam int CW = $clog2(LANES+1);
    localparam int WW = DATA_W*LANES;
    localparam logic [CW:0] L_FULL = (CW+1)'(LANES);

    logic [WW-1:0] r_pack;
    logic [CW-1:0] r_cnt;
    logic          r_rd_pend;
    logic          r_flush_req;
    logic          r_out_valid;
    logic [WW-1:0] r_out_data;
    logic [CW-1:0] r_out_bytes;

    logic [CW:0]   w_cnt_sum;
    logic [WW-1:0] w_pack_upd;
    logic [WW-1:0] w_pack_part;
    logic          w_slot_free;
    logic          w_rd_en;
    logic          w_load_full;
    logic          w_flush_go;
    logic          w_load_part;

    // Counting the in-flight read keeps the pack register from ever overflowing.
    always_comb begin
        w_cnt_sum   = {1'b0, r_cnt} + {{CW{1'b0}}, r_rd_pend};
        w_slot_free = !r_out_valid || out_ready;
        w_rd_en     = !rst && !fifo_empty && !r_flush_req && (w_cnt_sum < L_FULL);
        w_load_full = w_slot_free && (w_cnt_sum == L_FULL);
        w_flush_go  = r_flush_req && !r_rd_pend && w_slot_free;
        w_load_part = w_flush_go && (r_cnt != '0) && !w_load_full;
    end

    // Lanes at or above cnt may hold stale bytes from an earlier word; the
    // partial image zeroes them.
    always_comb begin
        w_pack_upd  = r_pack;
        w_pack_part = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_rd_pend && (r_cnt == CW'(i)))
                w_pack_upd[i*DATA_W +: DATA_W] = fifo_data;
            if (CW'(i) < r_cnt)
                w_pack_part[i*DATA_W +: DATA_W] = r_pack[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        r_pack <= w_pack_upd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rd_pend   <= 1'b0;
            r_flush_req <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_bytes <= '0;
        end else begin
            r_rd_pend <= w_rd_en;
            if (w_flush_go)
                r_flush_req <= 1'b0;
            else if (flush)
                r_flush_req <= 1'b1;

            if (w_load_full) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_pack_upd;
                r_out_bytes <= L_FULL[CW-1:0];
                r_cnt       <= '0;
            end else if (w_load_part) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_pack_part;
                r_out_bytes <= r_cnt;
                r_cnt       <= '0;
            end else begin
                r_cnt <= w_cnt_sum[CW-1:0];
                if (r_out_valid && out_ready)
                    r_out_valid <= 1'b0;
            end
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_bytes  = r_out_bytes;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: behavioural fifo with one-cycle read
// latency, output monitor, and hand-computed expected words.
`timescale 1ns/1ps
module tb_fifo_word_packer;
    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int CW     = $clog2(LANES+1);

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    fifo_empty;
    logic [DATA_W-1:0]       fifo_data = '0;
    logic                    fifo_rd_en;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W*LANES-1:0] out_data;
    logic [CW-1:0]           out_bytes;

    logic [7:0]  mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        force_empty;
    int          cyc_cnt = 0;
    int          rd_viol = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          seen;
    int          unstable;
    int          k;
    logic [31:0] exp6 [16];
    logic [31:0] wq [$];
    int          bq [$];
    int          tq [$];

    fifo_word_packer #(.DATA_W(DATA_W), .LANES(LANES)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_bytes  (out_bytes)
    );

    always #5 clk = ~clk;

    assign fifo_empty = force_empty || (rd_ptr >= wr_ptr);

    // Fifo model: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            wq.push_back(out_data);
            bq.push_back(int'(out_bytes));
            tq.push_back(cyc_cnt);
        end
        if (fifo_rd_en && fifo_empty)
            rd_viol <= rd_viol + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    task automatic clear_mon();
        wq.delete();
        bq.delete();
        tq.delete();
    endtask

    task automatic wait_words(input int n, input int budget, input string tag);
        int j;
        j = 0;
        while (wq.size() < n && j < budget) begin
            cyc();
            j++;
        end
        chk(tag, 64'(wq.size()), 64'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1; force_empty = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));

        // reset with a non-empty fifo
        cyc();
        chk("rst_rd_en", 64'(fifo_rd_en), 64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_bytes", 64'(out_bytes), 64'(0));

        // streaming with out_ready=1
        rst = 1'b0;
        clear_mon();
        wait_words(2, 40, "t1_count");
        chk("t1_w0", 64'(wq[0]), 64'h04030201);
        chk("t1_b0", 64'(bq[0]), 64'(4));
        chk("t1_w1", 64'(wq[1]), 64'h08070605);
        chk("t1_b1", 64'(bq[1]), 64'(4));
        chk("t1_gap", 64'(tq[1] - tq[0]), 64'(LANES + 1));

        // back-pressure: first word held, second word parked in pack register
        clear_mon();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        seen = 0; unstable = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (out_valid) begin
                seen++;
                if (out_data !== 32'h04030201 || out_bytes !== 3'd4) unstable++;
            end
        end
        chk("t2_valid_cycles", 64'(seen), 64'(12));
        chk("t2_unstable", 64'(unstable), 64'(0));
        chk("t2_rd_en_low", 64'(fifo_rd_en), 64'(0));
        chk("t2_all_read", 64'(rd_ptr), 64'(16));
        chk("t2_no_accept", 64'(wq.size()), 64'(0));
        out_ready = 1'b1;
        cyc();
        chk("t2_next_valid", 64'(out_valid), 64'(1));
        chk("t2_next_data", 64'(out_data), 64'h08070605);
        chk("t2_next_bytes", 64'(out_bytes), 64'(4));
        cyc();
        chk("t2_drained", 64'(out_valid), 64'(0));
        chk("t2_accepted", 64'(wq.size()), 64'(2));
        chk("t2_w0", 64'(wq[0]), 64'h04030201);

        // flush of a three-byte partial word
        clear_mon();
        push(8'hAA); push(8'hBB); push(8'hCC);
        repeat (6) cyc();
        chk("t3_no_early", 64'(wq.size()), 64'(0));
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        wait_words(1, 10, "t3_count");
        chk("t3_w0", 64'(wq[0]), 64'h00CCBBAA);
        chk("t3_b0", 64'(bq[0]), 64'(3));
        push(8'h21); push(8'h22); push(8'h23); push(8'h24);
        wait_words(2, 20, "t3_count2");
        chk("t3_w1", 64'(wq[1]), 64'h24232221);
        chk("t3_b1", 64'(bq[1]), 64'(4));

        // flush with nothing packed
        clear_mon();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        seen = 0;
        repeat (4) begin
            cyc();
            if (out_valid) seen++;
        end
        chk("t4_no_output", 64'(seen), 64'(0));
        push(8'h31); push(8'h32); push(8'h33); push(8'h34);
        #1;
        chk("t4_rd_resumes", 64'(fifo_rd_en), 64'(1));
        wait_words(1, 20, "t4_count");
        chk("t4_w0", 64'(wq[0]), 64'h34333231);

        // reset with two bytes packed and one read in flight
        clear_mon();
        push(8'h55); push(8'h66); push(8'h77);
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        chk("t5_valid", 64'(out_valid), 64'(0));
        chk("t5_data", 64'(out_data), 64'(0));
        chk("t5_bytes", 64'(out_bytes), 64'(0));
        push(8'h11); push(8'h12); push(8'h13); push(8'h14);
        #1;
        chk("t5_rd_en_in_rst", 64'(fifo_rd_en), 64'(0));
        cyc();
        rst = 1'b0;
        wait_words(1, 20, "t5_count");
        chk("t5_w0", 64'(wq[0]), 64'h14131211);
        repeat (6) cyc();
        chk("t5_no_extra", 64'(wq.size()), 64'(1));

        // random fifo_empty and out_ready over 64 bytes
        clear_mon();
        for (int i = 0; i < 64; i++) push(8'(i * 37 + 5));
        for (int w = 0; w < 16; w++)
            exp6[w] = {8'((4*w+3) * 37 + 5), 8'((4*w+2) * 37 + 5),
                       8'((4*w+1) * 37 + 5), 8'((4*w) * 37 + 5)};
        k = 0;
        while (wq.size() < 16 && k < 2000) begin
            force_empty = ($urandom_range(0, 2) == 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            cyc();
            k++;
        end
        force_empty = 1'b0;
        out_ready   = 1'b1;
        chk("t6_count", 64'(wq.size()), 64'(16));
        for (int w = 0; w < 16; w++) begin
            chk($sformatf("t6_w%0d", w), 64'(wq[w]), 64'(exp6[w]));
            chk($sformatf("t6_b%0d", w), 64'(bq[w]), 64'(4));
        end
        chk("t6_fifo_drained", 64'(rd_ptr), 64'(wr_ptr));
        chk("rd_while_empty", 64'(rd_viol), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
